// File: rtl/alu_share_ctrl_if.sv
// Bundle between the two requesters, the shared 6-bit ALU and alu_share_ctrl.
//   req_valid/req_ready  : per-requester request handshake (bit i = requester i)
//   req_op*/req_a*/req_b*: per-requester operation payload
//   rsp_valid/rsp_ready  : per-requester response handshake
//   rsp_data             : captured ALU bits {OF, ZF, result/CF[6:0]}
//   alu_sw/alu_ledr      : drive to / result from the shared combinational ALU
// master = requesters plus the ALU (environment side), slave = the controller.
interface alu_share_ctrl_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [2:0]  req_op0;
    logic [5:0]  req_a0;
    logic [5:0]  req_b0;
    logic [2:0]  req_op1;
    logic [5:0]  req_a1;
    logic [5:0]  req_b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [8:0]  rsp_data;
    logic [14:0] alu_sw;
    logic [14:0] alu_ledr;

    modport master (
        output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
        output rsp_ready, alu_ledr,
        input  req_ready, rsp_valid, rsp_data, alu_sw
    );

    modport slave (
        input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
        input  rsp_ready, alu_ledr,
        output req_ready, rsp_valid, rsp_data, alu_sw
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational 6-bit ALU between two
// requesters: accept one op, hold it on alu_sw for LAT cycles, capture
// alu_ledr[8:0], return it on the granted requester's response channel.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : request/response handshakes and ALU drive/result
//   busy       : high whenever the sequencer is not idle
//   op_count   : completed responses, wraps modulo 2^CNT_W
module alu_share_ctrl #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_ctrl_if.slave  bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam int unsigned       EXEC_W    = 4;
    localparam logic [EXEC_W-1:0] EXEC_LAST = EXEC_W'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q,    state_d;
    logic              ptr_q,      ptr_d;
    logic              gnt_q,      gnt_d;
    logic [EXEC_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [14:0]       sw_q,       sw_d;
    logic [8:0]        data_q,     data_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic              busy_q,     busy_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic [1:0]        req_ready_c;
    logic              sel;
    logic [5:0]        ledr_unused;

    // Upper ALU output bits (display-only on the board) are not captured.
    assign ledr_unused = bus.alu_ledr[14:9];

    // Next-state, grant and capture logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        exec_cnt_d  = exec_cnt_q;
        sw_d        = sw_q;
        data_d      = data_q;
        op_count_d  = op_count_q;
        req_ready_c = 2'b00;
        // Pointer breaks ties only; a lone requester always wins.
        sel         = (bus.req_valid == 2'b11) ? ptr_q : bus.req_valid[1];

        case (state_q)
            IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    req_ready_c[sel] = 1'b1;
                    sw_d       = sel ? {bus.req_op1, bus.req_a1, bus.req_b1}
                                     : {bus.req_op0, bus.req_a0, bus.req_b0};
                    gnt_d      = sel;
                    ptr_d      = ~sel;
                    exec_cnt_d = '0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                exec_cnt_d = exec_cnt_q + EXEC_W'(1);
                if (exec_cnt_q == EXEC_LAST) begin
                    data_d  = bus.alu_ledr[8:0];
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[gnt_q]) begin
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == RESP) ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
        busy_d      = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            gnt_q       <= 1'b0;
            exec_cnt_q  <= '0;
            sw_q        <= '0;
            data_q      <= '0;
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            exec_cnt_q  <= exec_cnt_d;
            sw_q        <= sw_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.alu_sw    = sw_q;
    assign busy          = busy_q;
    assign op_count      = op_count_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench: two controllers (LAT=1/CNT_W=8 and LAT=3/CNT_W=2) see
// the same operands and response-ready, each with its own request valids.
// A transaction-level reference model predicts every output each cycle.
module tb_alu_share_ctrl;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;
    localparam int unsigned CW_A  = 8;
    localparam int unsigned CW_B  = 2;

    localparam logic [14:0] S_ADD53 = {3'd0, 6'd5, 6'd3};
    localparam logic [14:0] S_OF    = {3'd0, 6'd32, 6'd32};
    localparam logic [14:0] S_AND   = {3'd3, 6'h2A, 6'h0F};
    localparam logic [14:0] S_ZERO  = {3'd0, 6'd0, 6'd0};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0][1:0] drv_valid;
    logic [1:0]      drv_rready;
    logic [2:0]      drv_op0, drv_op1;
    logic [5:0]      drv_a0, drv_b0, drv_a1, drv_b1;

    alu_share_ctrl_if ifa ();
    alu_share_ctrl_if ifb ();

    logic            busy_a, busy_b;
    logic [CW_A-1:0] cnt_a;
    logic [CW_B-1:0] cnt_b;

    // Shared-ALU behaviour: 7-bit result/CF, ZF on the 7-bit result, signed OF.
    function automatic logic [14:0] ref_alu(input logic [14:0] sw);
        int         a, b, sa, sb, res;
        logic [6:0] r;
        logic       of;
        a  = int'(sw[11:6]);
        b  = int'(sw[5:0]);
        sa = (a >= 32) ? a - 64 : a;
        sb = (b >= 32) ? b - 64 : b;
        of = 1'b0;
        case (sw[14:12])
            3'd0: begin res = sa + sb; r = 7'(a + b); of = (res > 31) || (res < -32); end
            3'd1: begin res = sa - sb; r = {(a < b), 6'(a - b)}; of = (res > 31) || (res < -32); end
            3'd2: r = {1'b0, 6'(~a)};
            3'd3: r = {1'b0, 6'(a & b)};
            3'd4: r = {1'b0, 6'(a | b)};
            3'd5: r = {1'b0, 6'(a ^ b)};
            3'd6: r = (sa < sb) ? 7'd1 : 7'd0;
            default: r = (a == b) ? 7'd1 : 7'd0;
        endcase
        return {sw[14:12], 3'b101, of, (r == 7'd0), r};
    endfunction

    assign ifa.req_valid = drv_valid[0];
    assign ifb.req_valid = drv_valid[1];
    assign ifa.req_op0 = drv_op0;  assign ifb.req_op0 = drv_op0;
    assign ifa.req_a0  = drv_a0;   assign ifb.req_a0  = drv_a0;
    assign ifa.req_b0  = drv_b0;   assign ifb.req_b0  = drv_b0;
    assign ifa.req_op1 = drv_op1;  assign ifb.req_op1 = drv_op1;
    assign ifa.req_a1  = drv_a1;   assign ifb.req_a1  = drv_a1;
    assign ifa.req_b1  = drv_b1;   assign ifb.req_b1  = drv_b1;
    assign ifa.rsp_ready = drv_rready;
    assign ifb.rsp_ready = drv_rready;
    assign ifa.alu_ledr = ref_alu(ifa.alu_sw);
    assign ifb.alu_ledr = ref_alu(ifb.alu_sw);

    alu_share_ctrl #(.LAT(LAT_A), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .busy(busy_a), .op_count(cnt_a)
    );
    alu_share_ctrl #(.LAT(LAT_B), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .busy(busy_b), .op_count(cnt_b)
    );

    logic [1:0][1:0]  o_rdy, o_rval;
    logic [1:0][8:0]  o_data;
    logic [1:0][14:0] o_sw;
    logic [1:0][7:0]  o_cnt;
    logic [1:0]       o_busy;
    assign o_rdy  = {ifb.req_ready, ifa.req_ready};
    assign o_rval = {ifb.rsp_valid, ifa.rsp_valid};
    assign o_data = {ifb.rsp_data, ifa.rsp_data};
    assign o_sw   = {ifb.alu_sw, ifa.alu_sw};
    assign o_cnt  = {8'(cnt_b), cnt_a};
    assign o_busy = {busy_b, busy_a};

    // Reference model: one outstanding op per controller, timed by accept cycle.
    bit          m_busy [2];
    bit          m_g    [2];
    bit          m_ptr  [2];
    int          m_acc  [2];
    logic [14:0] m_sw   [2];
    logic [8:0]  m_data [2];
    int unsigned m_cnt  [2];
    int          lat_of [2] = '{int'(LAT_A), int'(LAT_B)};
    int unsigned cmask  [2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
    bit          obs_log [2][$];
    int          cyc;
    int          n_checks, n_pass;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_g[k] = 1'b0; m_ptr[k] = 1'b0; m_acc[k] = 0;
            m_sw[k] = '0; m_data[k] = '0; m_cnt[k] = 0;
        end
    endtask

    // One cycle: drive just after negedge, check, advance model, wait next negedge.
    task automatic step(input logic [1:0][1:0] vv, input logic [14:0] s0,
                        input logic [14:0] s1, input logic [1:0] rr);
        logic [1:0]  exp_rdy, exp_rval;
        logic [14:0] alu_out;
        bit          g, in_resp;
        drv_valid = vv;
        {drv_op0, drv_a0, drv_b0} = s0;
        {drv_op1, drv_a1, drv_b1} = s1;
        drv_rready = rr;
        #1;
        for (int k = 0; k < 2; k++) begin
            in_resp = m_busy[k] && (cyc > m_acc[k] + lat_of[k]);
            exp_rdy = 2'b00;
            g       = 1'b0;
            if (!m_busy[k] && vv[k] != 2'b00) begin
                g       = (vv[k] == 2'b11) ? m_ptr[k] : vv[k][1];
                exp_rdy = g ? 2'b10 : 2'b01;
            end
            exp_rval = in_resp ? (m_g[k] ? 2'b10 : 2'b01) : 2'b00;
            check_eq($sformatf("req_ready[%0d]", k), 32'(o_rdy[k]), 32'(exp_rdy));
            check_eq($sformatf("rsp_valid[%0d]", k), 32'(o_rval[k]), 32'(exp_rval));
            check_eq($sformatf("rsp_data[%0d]", k), 32'(o_data[k]), 32'(m_data[k]));
            check_eq($sformatf("alu_sw[%0d]", k), 32'(o_sw[k]), 32'(m_sw[k]));
            check_eq($sformatf("busy[%0d]", k), 32'(o_busy[k]), 32'(m_busy[k]));
            check_eq($sformatf("op_count[%0d]", k), 32'(o_cnt[k]), m_cnt[k] & cmask[k]);
            if (o_rdy[k] != 2'b00) obs_log[k].push_back(o_rdy[k][1]);
            if (exp_rdy != 2'b00) begin
                m_busy[k] = 1'b1; m_g[k] = g; m_ptr[k] = ~g; m_acc[k] = cyc;
                m_sw[k] = g ? s1 : s0;
            end else if (m_busy[k] && cyc == m_acc[k] + lat_of[k]) begin
                alu_out   = ref_alu(m_sw[k]);
                m_data[k] = alu_out[8:0];
            end else if (in_resp && rr[m_g[k]]) begin
                m_busy[k] = 1'b0;
                m_cnt[k]++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        drv_valid = '0;
        drv_rready = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("rst_ready[%0d]", k), 32'(o_rdy[k]), 32'd0);
            check_eq($sformatf("rst_rval[%0d]", k), 32'(o_rval[k]), 32'd0);
            check_eq($sformatf("rst_data[%0d]", k), 32'(o_data[k]), 32'd0);
            check_eq($sformatf("rst_sw[%0d]", k), 32'(o_sw[k]), 32'd0);
            check_eq($sformatf("rst_busy[%0d]", k), 32'(o_busy[k]), 32'd0);
            check_eq($sformatf("rst_cnt[%0d]", k), 32'(o_cnt[k]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m_busy[0] || m_busy[1]); i++)
            step(4'b0000, 15'h0, 15'h0, 2'b11);
        check_eq("drain_busy", 32'(o_busy), 32'd0);
    endtask

    // Keep both requesters valid on each controller until it has granted `target` times.
    task automatic run_both(input int target, input logic [14:0] s0, input logic [14:0] s1);
        logic [1:0][1:0] vv;
        for (int i = 0; i < 300; i++) begin
            if (obs_log[0].size() >= target && obs_log[1].size() >= target &&
                !m_busy[0] && !m_busy[1]) break;
            for (int k = 0; k < 2; k++)
                vv[k] = (obs_log[k].size() < target) ? 2'b11 : 2'b00;
            step(vv, s0, s1, 2'b11);
        end
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("grants[%0d]", k), 32'(obs_log[k].size()), 32'(target));
        check_eq("run_busy", 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic [1:0][1:0] rv;
        n_checks = 0; n_pass = 0; cyc = 0;
        drv_valid = '0; drv_rready = 2'b00;
        {drv_op0, drv_a0, drv_b0} = 15'h0;
        {drv_op1, drv_a1, drv_b1} = 15'h0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single add from requester 0.
        step(4'b0101, S_ADD53, 15'h0, 2'b00);
        step(4'b0000, 15'h0, 15'h0, 2'b00);
        step(4'b0000, 15'h0, 15'h0, 2'b00);
        check_eq("add53_sw", 32'(o_sw[0]), 32'h0143);
        check_eq("add53_data", 32'(o_data[0]), 32'h008);
        check_eq("add53_rval", 32'(o_rval[0]), 32'h1);
        drain();
        check_eq("add53_cnt_a", 32'(o_cnt[0]), 32'd1);
        check_eq("add53_cnt_b", 32'(o_cnt[1]), 32'd1);

        // Both valid after reset: requester 0 first, then 1; then 6 alternating.
        do_reset();
        for (int k = 0; k < 2; k++) obs_log[k].delete();
        run_both(2, S_OF, S_AND);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("first_gnt[%0d]", k), 32'(obs_log[k][0]), 32'd0);
            check_eq($sformatf("second_gnt[%0d]", k), 32'(obs_log[k][1]), 32'd1);
            check_eq($sformatf("and_data_held[%0d]", k), 32'(o_data[k]), 32'h00A);
            obs_log[k].delete();
        end
        run_both(6, S_OF, S_AND);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 6; i++)
                check_eq($sformatf("alt_gnt[%0d][%0d]", k, i), 32'(obs_log[k][i]), 32'(i % 2));
        check_eq("cnt8_a", 32'(o_cnt[0]), 32'd8);
        check_eq("cnt8_b_wrap", 32'(o_cnt[1]), 32'd0);

        // Requester 1 stalled on rsp_ready; inputs churn, rsp_ready[0] ignored.
        step(4'b1010, 15'h7FFF, S_ZERO, 2'b00);
        for (int i = 0; i < 8; i++)
            step(4'($urandom), 15'($urandom), 15'($urandom), 2'b01);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("stall_data[%0d]", k), 32'(o_data[k]), 32'h080);
            check_eq($sformatf("stall_rval[%0d]", k), 32'(o_rval[k]), 32'h2);
            check_eq($sformatf("stall_busy[%0d]", k), 32'(o_busy[k]), 32'd1);
        end
        drain();

        // Reset while executing: op dropped, priority back to requester 0.
        step(4'b1010, 15'($urandom), 15'($urandom), 2'b11);
        do_reset();
        for (int i = 0; i < 6; i++) step(4'b0000, 15'h0, 15'h0, 2'b11);
        for (int k = 0; k < 2; k++) obs_log[k].delete();
        run_both(2, 15'($urandom), 15'($urandom));
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("prio_after_rst[%0d]", k), 32'(obs_log[k][0]), 32'd0);
        step(4'b1010, 15'($urandom), 15'($urandom), 2'b11);
        drain();

        // Random traffic: valids, operands and response back-pressure.
        for (int i = 0; i < 800; i++) begin
            rv = 4'($urandom);
            step(rv, 15'($urandom), 15'($urandom), 2'($urandom));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
